// File: rtl/uart_tx_framed_if.sv
// Producer-side handshake bundle for uart_tx_framed.
//   master : the producer (drives character, per-character config and valid)
//   slave  : the transmitter (drives ready)
// Signals:
//   data_in[DATA_BITS]  character, sent LSB first
//   parity_mode[2]      00 none, 01 odd, 10 even, 11 mark
//   two_stop            0 one stop bit, 1 two stop bits
//   data_in_valid       producer has a character
//   data_in_ready       transmitter holding register is empty
`timescale 1ns/1ps
interface uart_tx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic [1:0]           parity_mode;
    logic                 two_stop;
    logic                 data_in_valid;
    logic                 data_in_ready;

    modport master (
        output data_in,
        output parity_mode,
        output two_stop,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  parity_mode,
        input  two_stop,
        input  data_in_valid,
        output data_in_ready
    );
endinterface

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: configurable character width, per-character parity
// and stop-bit count, with a one-entry holding register so the next character
// can be queued while the current frame shifts out (no idle gap between frames).
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   in_if       producer handshake (slave modport): data_in, parity_mode,
//               two_stop, data_in_valid in; data_in_ready out
//   serial_out  registered TX line, idles high
//   tx_busy     frame in progress or holding register full
//   frame_done  one-cycle pulse in the last cycle of the final stop bit
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line high, waiting for the holding register to fill
// S_START  | start bit (0) on the line
// S_DATA   | data bits, LSB first, bit_idx_q counts 0..DATA_BITS-1
// S_PARITY | parity bit for the current character
// S_STOP   | one or two stop bits (1); may chain straight into S_START
`timescale 1ns/1ps
module uart_tx_framed #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_framed_if.slave   in_if,
    output logic              serial_out,
    output logic              tx_busy,
    output logic              frame_done
);

    // SYMBOL_EDGE_TIME must be at least 2 for the frame_done look-ahead below.
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SYMBOL_EDGE_TIME - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 two_stop_q;

    logic [DATA_BITS-1:0] hold_data_q;
    logic [1:0]           hold_pm_q;
    logic                 hold_ts_q;
    logic                 hold_full_q;

    logic                 serial_out_q;
    logic                 frame_done_q;

    logic                 accept;
    logic                 sym_edge;
    logic                 last_stop;
    logic                 load;
    logic                 par_bit_d;

    assign in_if.data_in_ready = !hold_full_q;
    assign accept     = in_if.data_in_valid && !hold_full_q;
    assign sym_edge   = (cnt_q == CNT_LAST);
    assign last_stop  = (stop_idx_q == two_stop_q);

    // The shifter reloads either from idle or exactly at the edge that ends
    // the final stop symbol, which is what removes the inter-frame gap.
    assign load = hold_full_q &&
                  ((state_q == S_IDLE) ||
                   (state_q == S_STOP && sym_edge && last_stop));

    // Parity is resolved from the held character so the frame in flight never
    // sees config belonging to the next character.
    always_comb begin
        par_bit_d = 1'b1;
        case (hold_pm_q)
            2'b01:   par_bit_d = ~(^hold_data_q);
            2'b10:   par_bit_d = ^hold_data_q;
            default: par_bit_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            two_stop_q   <= 1'b0;
            hold_data_q  <= '0;
            hold_pm_q    <= 2'b00;
            hold_ts_q    <= 1'b0;
            hold_full_q  <= 1'b0;
            serial_out_q <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            if (state_q == S_IDLE || sym_edge) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (load) begin
                state_q      <= S_START;
                shift_q      <= hold_data_q;
                par_en_q     <= (hold_pm_q != 2'b00);
                par_bit_q    <= par_bit_d;
                two_stop_q   <= hold_ts_q;
                hold_full_q  <= 1'b0;
                serial_out_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        serial_out_q <= 1'b1;
                    end
                    S_START: begin
                        if (sym_edge) begin
                            state_q      <= S_DATA;
                            bit_idx_q    <= '0;
                            serial_out_q <= shift_q[0];
                            shift_q      <= shift_q >> 1;
                        end
                    end
                    S_DATA: begin
                        if (sym_edge) begin
                            if (bit_idx_q == IDX_LAST) begin
                                if (par_en_q) begin
                                    state_q      <= S_PARITY;
                                    serial_out_q <= par_bit_q;
                                end else begin
                                    state_q      <= S_STOP;
                                    stop_idx_q   <= 1'b0;
                                    serial_out_q <= 1'b1;
                                end
                            end else begin
                                bit_idx_q    <= bit_idx_q + 1'b1;
                                serial_out_q <= shift_q[0];
                                shift_q      <= shift_q >> 1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (sym_edge) begin
                            state_q      <= S_STOP;
                            stop_idx_q   <= 1'b0;
                            serial_out_q <= 1'b1;
                        end
                    end
                    S_STOP: begin
                        // Registered pulse: set one cycle early so it lands
                        // in the final cycle of the last stop symbol.
                        if (last_stop && cnt_q == CNT_PRE) begin
                            frame_done_q <= 1'b1;
                        end
                        if (sym_edge) begin
                            if (!last_stop) begin
                                stop_idx_q <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                            end
                            serial_out_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q      <= S_IDLE;
                        serial_out_q <= 1'b1;
                    end
                endcase
            end

            // Cannot coincide with load: ready is low whenever hold_full_q is set.
            if (accept) begin
                hold_data_q <= in_if.data_in;
                hold_pm_q   <= in_if.parity_mode;
                hold_ts_q   <= in_if.two_stop;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign serial_out = serial_out_q;
    assign frame_done = frame_done_q;
    assign tx_busy    = (state_q != S_IDLE) || hold_full_q;

endmodule

// File: tb/tb_uart_tx_framed.sv
`timescale 1ns/1ps
module tb_uart_tx_framed;

    localparam int CF  = 1_000_000;
    localparam int BR  = 100_000;
    localparam int SET = CF / BR;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_framed_if #(.DATA_BITS(8)) bus8 ();
    uart_tx_framed_if #(.DATA_BITS(7)) bus7 ();

    logic so8, busy8, fd8;
    logic so7, busy7, fd7;

    uart_tx_framed #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .in_if      (bus8.slave),
        .serial_out (so8),
        .tx_busy    (busy8),
        .frame_done (fd8)
    );

    uart_tx_framed #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7)) dut7 (
        .clk        (clk),
        .reset      (reset),
        .in_if      (bus7.slave),
        .serial_out (so7),
        .tx_busy    (busy7),
        .frame_done (fd7)
    );

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    frame_t sb8[$];
    frame_t sb7[$];
    int     starts8[$];

    frame_t m_f      [2];
    bit     m_active [2];
    bit     m_err    [2];
    bit     m_prev   [2];
    int     m_cyc    [2];
    int     m_frames [2];

    // Reference frame: start, data LSB first, optional parity, stop bits.
    function automatic frame_t build(input logic [8:0] data, input int dbits,
                                     input logic [1:0] pm, input logic ts);
        frame_t f;
        logic   p;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        f.n       = 1;
        p         = 1'b0;
        for (int i = 0; i < dbits; i++) begin
            f.bits[f.n] = data[i];
            p = p ^ data[i];
            f.n++;
        end
        if (pm == 2'b01) begin
            f.bits[f.n] = ~p;
            f.n++;
        end else if (pm == 2'b10) begin
            f.bits[f.n] = p;
            f.n++;
        end else if (pm == 2'b11) begin
            f.bits[f.n] = 1'b1;
            f.n++;
        end
        f.n = f.n + 1 + (ts ? 1 : 0);
        return f;
    endfunction

    function automatic int sb_size(input int d);
        return (d == 0) ? sb8.size() : sb7.size();
    endfunction

    // Scoreboard consumer: pops a frame on each start bit and checks every
    // cycle of it (line level and frame_done) against the reference.
    task automatic mon_step(input int d, input logic so, input logic fd);
        logic exp_so;
        logic exp_fd;
        if (!m_active[d]) begin
            if (so === 1'b0) begin
                if (sb_size(d) == 0) begin
                    if (m_prev[d] !== 1'b0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_start dut%0d: serial_out=0 at cycle %0d, required 1 (nothing queued)", d, cyc);
                    end
                end else begin
                    m_f[d]      = (d == 0) ? sb8.pop_front() : sb7.pop_front();
                    m_active[d] = 1'b1;
                    m_err[d]    = 1'b0;
                    m_cyc[d]    = 0;
                    if (d == 0) starts8.push_back(cyc);
                end
            end else if (fd === 1'b1) begin
                vectors++;
                miscompares++;
                $display("FAIL frame_done_idle dut%0d: frame_done=1 at cycle %0d, required 0", d, cyc);
            end
        end
        if (m_active[d]) begin
            exp_so = m_f[d].bits[m_cyc[d] / SET];
            exp_fd = (m_cyc[d] == m_f[d].n * SET - 1);
            if (!m_err[d] && (so !== exp_so || fd !== exp_fd)) begin
                m_err[d] = 1'b1;
                $display("FAIL frame dut%0d cycle %0d of frame: serial_out=%b frame_done=%b, required %b/%b",
                         d, m_cyc[d], so, fd, exp_so, exp_fd);
            end
            m_cyc[d]++;
            if (m_cyc[d] == m_f[d].n * SET) begin
                m_active[d] = 1'b0;
                m_frames[d]++;
                vectors++;
                if (m_err[d]) miscompares++;
            end
        end
        m_prev[d] = so;
    endtask

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            m_active[0] = 1'b0;
            m_active[1] = 1'b0;
        end else begin
            mon_step(0, so8, fd8);
            mon_step(1, so7, fd7);
        end
    end

    task automatic wait_idle(input int d, input int budget, input string name);
        int n = 0;
        while (n < budget &&
               !(sb_size(d) == 0 && !m_active[d] &&
                 ((d == 0) ? busy8 : busy7) === 1'b0)) begin
            @(negedge clk); #1;
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s_idle_timeout: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic send8(input logic [7:0] data, input logic [1:0] pm, input logic ts);
        int n = 0;
        @(negedge clk); #1;
        bus8.data_in       = data;
        bus8.parity_mode   = pm;
        bus8.two_stop      = ts;
        bus8.data_in_valid = 1'b1;
        while (bus8.data_in_ready !== 1'b1 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: data_in_ready=%b, required 1", bus8.data_in_ready);
        end else begin
            sb8.push_back(build({1'b0, data}, 8, pm, ts));
        end
        @(posedge clk); #1;
        bus8.data_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus8.data_in = '0; bus8.parity_mode = 2'b00; bus8.two_stop = 1'b0; bus8.data_in_valid = 1'b0;
        bus7.data_in = '0; bus7.parity_mode = 2'b00; bus7.two_stop = 1'b0; bus7.data_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (so8 !== 1'b1) begin miscompares++; $display("FAIL reset_serial_out: got %b, required 1", so8); end
        vectors++; if (bus8.data_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, required 1", bus8.data_in_ready); end
        vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy8); end
        vectors++; if (fd8 !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b, required 0", fd8); end
        vectors++; if (so7 !== 1'b1) begin miscompares++; $display("FAIL reset_serial_out7: got %b, required 1", so7); end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_8n1();
        @(negedge clk); #1;
        bus8.data_in = 8'hA5; bus8.parity_mode = 2'b00; bus8.two_stop = 1'b0; bus8.data_in_valid = 1'b1;
        vectors++; if (bus8.data_in_ready !== 1'b1) begin miscompares++; $display("FAIL 8n1_ready_pre: got %b, required 1", bus8.data_in_ready); end
        sb8.push_back(build(9'h0A5, 8, 2'b00, 1'b0));
        @(posedge clk); #1;
        bus8.data_in_valid = 1'b0;
        vectors++; if (bus8.data_in_ready !== 1'b0) begin miscompares++; $display("FAIL 8n1_ready_k: got %b, required 0", bus8.data_in_ready); end
        vectors++; if (so8 !== 1'b1) begin miscompares++; $display("FAIL 8n1_line_k: got %b, required 1", so8); end
        vectors++; if (busy8 !== 1'b1) begin miscompares++; $display("FAIL 8n1_busy_k: got %b, required 1", busy8); end
        @(posedge clk); #1;
        vectors++; if (so8 !== 1'b0) begin miscompares++; $display("FAIL 8n1_start_k1: got %b, required 0", so8); end
        vectors++; if (bus8.data_in_ready !== 1'b1) begin miscompares++; $display("FAIL 8n1_ready_k1: got %b, required 1", bus8.data_in_ready); end
        wait_idle(0, 400, "8n1");
        vectors++; if (m_frames[0] !== 1) begin miscompares++; $display("FAIL 8n1_frame_count: got %0d, required 1", m_frames[0]); end
    endtask

    task automatic test_parity();
        int f0 = m_frames[0];
        send8(8'hA5, 2'b10, 1'b0);
        send8(8'hA5, 2'b01, 1'b0);
        send8(8'hA5, 2'b11, 1'b0);
        wait_idle(0, 1500, "parity");
        vectors++; if (m_frames[0] - f0 !== 3) begin miscompares++; $display("FAIL parity_frame_count: got %0d, required 3", m_frames[0] - f0); end
    endtask

    task automatic test_two_stop7();
        int n = 0;
        @(negedge clk); #1;
        bus7.data_in = 7'h41; bus7.parity_mode = 2'b00; bus7.two_stop = 1'b1; bus7.data_in_valid = 1'b1;
        while (bus7.data_in_ready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
        sb7.push_back(build(9'h041, 7, 2'b00, 1'b1));
        @(posedge clk); #1;
        bus7.data_in_valid = 1'b0;
        wait_idle(1, 400, "two_stop7");
        vectors++; if (m_frames[1] !== 1) begin miscompares++; $display("FAIL two_stop7_frame_count: got %0d, required 1", m_frames[1]); end
    endtask

    task automatic test_back_to_back();
        int  f0 = m_frames[0];
        int  n = 0;
        bit  bad = 1'b0;
        send8(8'h55, 2'b00, 1'b0);
        send8(8'h0F, 2'b00, 1'b0);
        vectors++; if (bus8.data_in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_after_accept: got %b, required 0", bus8.data_in_ready); end
        while (!(m_frames[0] == f0 + 1 && m_active[0]) && n < 400) begin
            if (bus8.data_in_ready !== 1'b0) bad = 1'b1;
            @(negedge clk); #1;
            n++;
        end
        vectors++; if (bad || n >= 400) begin miscompares++; $display("FAIL b2b_ready_low: ready rose early=%b timeout=%b, required low until second start", bad, n >= 400); end
        vectors++; if (bus8.data_in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_second_start: got %b, required 1", bus8.data_in_ready); end
        wait_idle(0, 400, "b2b");
        vectors++;
        if (starts8.size() < 2 || starts8[starts8.size()-1] - starts8[starts8.size()-2] != 10 * SET) begin
            miscompares++;
            $display("FAIL b2b_gap: start spacing %0d cycles, required %0d",
                     (starts8.size() < 2) ? -1 : starts8[starts8.size()-1] - starts8[starts8.size()-2], 10 * SET);
        end
    endtask

    task automatic test_backpressure();
        int      accepted = 0;
        int      n = 0;
        int      f0 = m_frames[0];
        logic [7:0] d;
        logic [1:0] pm;
        logic       ts;
        @(negedge clk); #1;
        bus8.data_in_valid = 1'b1;
        while (accepted < 3 && n < 3000) begin
            d  = 8'($urandom);
            pm = 2'($urandom_range(0, 3));
            ts = 1'($urandom_range(0, 1));
            bus8.data_in = d; bus8.parity_mode = pm; bus8.two_stop = ts;
            if (bus8.data_in_ready === 1'b1) begin
                sb8.push_back(build({1'b0, d}, 8, pm, ts));
                accepted++;
            end
            @(negedge clk); #1;
            n++;
        end
        bus8.data_in_valid = 1'b0;
        wait_idle(0, 1500, "backpressure");
        vectors++; if (m_frames[0] - f0 !== 3) begin miscompares++; $display("FAIL backpressure_frame_count: got %0d, required 3", m_frames[0] - f0); end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        bit bad = 1'b0;
        send8(8'h3C, 2'b10, 1'b0);
        while (!m_active[0] && n < 50) begin @(negedge clk); #1; n++; end
        send8(8'h99, 2'b00, 1'b1);
        n = 0;
        while (!(m_active[0] && m_cyc[0] >= 44) && n < 200) begin @(negedge clk); #1; n++; end
        #1;
        reset = 1'b0;
        #1;
        vectors++; if (so8 !== 1'b1) begin miscompares++; $display("FAIL midreset_serial_out: got %b, required 1", so8); end
        vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b, required 0", busy8); end
        vectors++; if (bus8.data_in_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_ready: got %b, required 1", bus8.data_in_ready); end
        sb8.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (so8 !== 1'b1 || busy8 !== 1'b0) bad = 1'b1;
        end
        vectors++; if (bad) begin miscompares++; $display("FAIL midreset_quiet: line/busy activity after release, required idle"); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0; m_err[i] = 1'b0; m_prev[i] = 1'b1;
            m_cyc[i] = 0; m_frames[i] = 0;
        end
        test_reset();
        test_8n1();
        test_parity();
        test_two_stop7();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_framed.md
# uart_tx_framed

Parametrised UART transmitter that serialises characters of configurable width, with per-character parity and stop-bit selection. A one-entry holding register lets the upstream producer queue the next character while the current frame shifts out, so back-to-back frames go out with no idle gap. It sits between a byte/word producer (FIFO or memory-mapped register) and the board's serial TX pin, and replaces the fixed 8N1 transmitter.

## Interface
- `CLOCK_FREQ`, 125_000_000, input clock frequency in Hz.
- `BAUD_RATE`, 115_200, line rate in symbols/s.
  - Symbol period `SYMBOL_EDGE_TIME` = CLOCK_FREQ / BAUD_RATE (integer floor), which must be ≥ 2.
  - Counter width = $clog2(SYMBOL_EDGE_TIME).
- `DATA_BITS`, 8, character width, legal range 5..9.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to `clk`.
- `data_in`  input  DATA_BITS  character, transmitted LSB first.
- `parity_mode`  input  2  sampled with `data_in`:
  - 00 = none
  - 01 = odd
  - 10 = even
  - 11 = mark (constant 1)
- `two_stop`  input  1  sampled with `data_in`; 0 = one stop bit, 1 = two stop bits.
- `data_in_valid`  input  1  producer has a character.
- `data_in_ready`  output  1  holding register empty.
- `serial_out`  output  1  registered line output; idles high.
- `tx_busy`  output  1  frame in progress or holding register full.
- `frame_done`  output  1  one-cycle pulse in the last cycle of each frame's final stop bit.

## Operation
- **Accept.** A character is accepted on a rising edge where `data_in_valid && data_in_ready`.
  - `data_in`, `parity_mode` and `two_stop` are captured into the holding register, and the holding register is marked full.
  - `data_in_ready` = !hold_full (combinational from the flag).
- **Frame layout.** Start (0), then DATA_BITS data bits LSB first, then the optional parity bit, then 1 or 2 stop bits (1).
  - Frame length N = 1 + DATA_BITS + (parity_mode != 0) + 1 + two_stop symbols.
- **Parity** is computed over the DATA_BITS data bits only:
  - even: XOR of the bits
  - odd: inverted XOR
  - mark: 1
- **State machine:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when hold_full. The shifter loads from the holding register and hold_full clears on the same edge.
  - START → DATA after one symbol.
  - DATA → PARITY or STOP after DATA_BITS symbols. A bit index counts 0..DATA_BITS-1.
  - PARITY → STOP after one symbol.
  - STOP → START directly if hold_full at the final stop-symbol edge (no idle cycles); otherwise STOP → IDLE.
- **Symbol timing.** A cycle counter runs 0..SYMBOL_EDGE_TIME-1 in every non-IDLE state.
  - It is cleared on entry to START and at every symbol edge.
  - It is held at 0 in IDLE.
- **serial_out** is 1 in IDLE and otherwise follows the current symbol bit.
- **Config scope.** A config change on the inputs affects only characters accepted after the change, never the frame in flight.

## Timing
- **Reset values:**
  - `serial_out` = 1
  - `data_in_ready` = 1
  - `tx_busy` = 0
  - `frame_done` = 0
  - state IDLE, hold_full = 0, counters = 0
- **Latency from idle.** Accept at edge k → START entered and `serial_out` = 0 after edge k+1.
  - `data_in_ready` is 0 between edge k and edge k+1, then 1 again.
  - A second character may be accepted at edge k+1.
- **Symbol duration.** Each symbol holds `serial_out` for exactly SYMBOL_EDGE_TIME cycles, so a frame lasts N × SYMBOL_EDGE_TIME cycles.
- **Back-to-back frames.** The next start bit begins on the edge that ends the last stop symbol.
  - `frame_done` pulses in the preceding cycle.
- **Accept while holding register full.** Ignored; `data_in_ready` is 0 and the holding contents are unchanged.
- **Accept on the transfer edge.** An accept on the same edge that the holding register transfers to the shifter is impossible, because ready was 0 in that cycle.
- **Reset mid-frame.** `serial_out` goes to 1 asynchronously and the queued character is discarded. No partial frame resumes after release.

## Test plan
- **8N1, single character.** CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, 0xA5, parity 00, one stop.
  - `serial_out` = 0,1,0,1,0,0,1,0,1,1, each for 10 cycles, then idle high.
  - `frame_done` pulses at cycle 100 of the frame.
- **Parity.** 0xA5 with even parity → parity bit 0; with odd → 1; with mark → 1. Frame is 11 symbols (110 cycles).
- **Two stop bits, 7 data bits.** 0x41, DATA_BITS=7, two_stop=1, no parity → start, 1,0,0,0,0,0,1, then high for 20 cycles; frame is 100 cycles.
- **Back-to-back.** 0x55 accepted, then 0x0F accepted one cycle later.
  - The second start bit begins on the exact cycle after 0x55's stop bit: total 200 cycles with no idle gap.
  - `data_in_ready` is low from the second accept until the second frame starts.
- **Backpressure.** Hold `data_in_valid` high with changing data while full → only the values present on accepting edges are transmitted.
- **Reset mid-frame.** Assert `reset` low in the 4th data bit with a character queued.
  - `serial_out` = 1 immediately, `tx_busy` = 0, `data_in_ready` = 1.
  - Nothing is transmitted after release until a new accept.
